// File: rtl/ramsp_arb.sv
// Two-port arbiter in front of one single-port RAM: round-robin grant, one access per cycle,
// latency-1 read return steered back to the port that issued the read.
module ramsp_arb #(
   parameter int DW = 16,
   parameter int AW = 10
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          a_req,
   input  logic          a_we,
   input  logic [AW-1:0] a_addr,
   input  logic [DW-1:0] a_din,
   output logic          a_gnt,
   output logic          a_rvalid,
   output logic [DW-1:0] a_rdata,
   input  logic          b_req,
   input  logic          b_we,
   input  logic [AW-1:0] b_addr,
   input  logic [DW-1:0] b_din,
   output logic          b_gnt,
   output logic          b_rvalid,
   output logic [DW-1:0] b_rdata,
   output logic          mem_we,
   output logic [AW-1:0] mem_addr,
   output logic [DW-1:0] mem_din,
   input  logic [DW-1:0] mem_dout,
   output logic [15:0]   stall_cnt
);
   localparam int NP = 2;

   logic [NP-1:0]         req, we, gnt, rvalid;
   logic [NP-1:0][AW-1:0] addr;
   logic [NP-1:0][DW-1:0] din, rdata;
   logic                  prio;     // 0 favours A, 1 favours B
   logic                  rd_vld;
   logic                  rd_own;   // port that issued last cycle's read
   logic [15:0]           stall_q;

   assign req  = {b_req, a_req};
   assign we   = {b_we, a_we};
   assign addr = {b_addr, a_addr};
   assign din  = {b_din, a_din};

   always_comb begin
      gnt = '0;
      if (!rst) begin
         if (req[0] && (!req[1] || !prio))
            gnt[0] = 1'b1;
         else if (req[1])
            gnt[1] = 1'b1;
      end
   end

   assign a_gnt = gnt[0];
   assign b_gnt = gnt[1];

   always_comb begin
      mem_we   = 1'b0;
      mem_addr = '0;
      mem_din  = '0;
      for (int p = 0; p < NP; p++) begin
         if (gnt[p]) begin
            mem_we   = we[p];
            mem_addr = addr[p];
            mem_din  = din[p];
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         prio   <= 1'b0;
         rd_vld <= 1'b0;
         rd_own <= 1'b0;
      end else begin
         if (gnt[0])
            prio <= 1'b1;
         else if (gnt[1])
            prio <= 1'b0;
         rd_vld <= |(gnt & ~we);
         rd_own <= gnt[1];
      end
   end

   // Saturating count of cycles where some requester was left waiting.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         stall_q <= '0;
      else if (|(req & ~gnt) && stall_q != 16'hFFFF)
         stall_q <= stall_q + 16'd1;
   end

   assign stall_cnt = stall_q;

   genvar g;
   generate
      for (g = 0; g < NP; g++) begin : g_ret
         assign rvalid[g] = rd_vld && (rd_own == 1'(g)) && !rst;
         assign rdata[g]  = rvalid[g] ? mem_dout : '0;
      end
   endgenerate

   assign a_rvalid = rvalid[0];
   assign b_rvalid = rvalid[1];
   assign a_rdata  = rdata[0];
   assign b_rdata  = rdata[1];
endmodule

// File: tb/tb_ramsp_arb.sv
// Directed bench for ramsp_arb with a behavioural read-before-write single-port RAM.
module tb_ramsp_arb;
   localparam int DW = 16;
   localparam int AW = 10;

   logic          clk = 1'b0;
   logic          rst;
   logic          a_req, a_we, b_req, b_we;
   logic [AW-1:0] a_addr, b_addr;
   logic [DW-1:0] a_din, b_din;
   logic          a_gnt, a_rvalid, b_gnt, b_rvalid;
   logic [DW-1:0] a_rdata, b_rdata;
   logic          mem_we;
   logic [AW-1:0] mem_addr;
   logic [DW-1:0] mem_din;
   logic [DW-1:0] mem_dout;
   logic [15:0]   stall_cnt;

   logic [DW-1:0] ram [0:(1<<AW)-1];

   int checks = 0;
   int errors = 0;
   int na, nb;

   ramsp_arb #(.DW(DW), .AW(AW)) dut (
      .clk(clk), .rst(rst),
      .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_din(a_din),
      .a_gnt(a_gnt), .a_rvalid(a_rvalid), .a_rdata(a_rdata),
      .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_din(b_din),
      .b_gnt(b_gnt), .b_rvalid(b_rvalid), .b_rdata(b_rdata),
      .mem_we(mem_we), .mem_addr(mem_addr), .mem_din(mem_din),
      .mem_dout(mem_dout), .stall_cnt(stall_cnt)
   );

   always #5 clk = ~clk;

   // RAM contents are preloaded as addr ^ 16'hA500 while reset is held.
   always @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < (1<<AW); i++) ram[i] <= DW'(i) ^ 16'hA500;
         mem_dout <= '0;
      end else begin
         if (mem_we) ram[mem_addr] <= mem_din;
         mem_dout <= ram[mem_addr];
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   initial begin
      rst = 1'b1;
      a_req = 1'b1; a_we = 1'b0; a_addr = 10'd5; a_din = '0;
      b_req = 1'b1; b_we = 1'b0; b_addr = 10'd9; b_din = '0;
      @(negedge clk); @(negedge clk); #1;
      chk("rst_agnt", 32'(a_gnt), 32'd0);
      chk("rst_bgnt", 32'(b_gnt), 32'd0);
      chk("rst_mem_we", 32'(mem_we), 32'd0);
      chk("rst_mem_addr", 32'(mem_addr), 32'd0);
      chk("rst_arv", 32'(a_rvalid), 32'd0);
      chk("rst_ardata", 32'(a_rdata), 32'd0);
      chk("rst_stall", 32'(stall_cnt), 32'd0);

      // both read, A first then B
      @(negedge clk); rst = 1'b0; #1;
      chk("c0_agnt", 32'(a_gnt), 32'd1);
      chk("c0_bgnt", 32'(b_gnt), 32'd0);
      chk("c0_addr", 32'(mem_addr), 32'd5);
      @(negedge clk); a_req = 1'b0; #1;
      chk("c1_bgnt", 32'(b_gnt), 32'd1);
      chk("c1_addr", 32'(mem_addr), 32'd9);
      chk("c1_arv", 32'(a_rvalid), 32'd1);
      chk("c1_ardata", 32'(a_rdata), 32'hA505);
      chk("c1_stall", 32'(stall_cnt), 32'd1);
      @(negedge clk); b_req = 1'b0; #1;
      chk("c2_brv", 32'(b_rvalid), 32'd1);
      chk("c2_brdata", 32'(b_rdata), 32'hA509);
      chk("c2_arv", 32'(a_rvalid), 32'd0);
      chk("c2_idle_addr", 32'(mem_addr), 32'd0);
      chk("c2_idle_din", 32'(mem_din), 32'd0);
      chk("c2_stall", 32'(stall_cnt), 32'd1);

      // A writes 1234 to addr 3 then reads it back
      @(negedge clk); a_req = 1'b1; a_we = 1'b1; a_addr = 10'd3; a_din = 16'h1234; #1;
      chk("wr_gnt", 32'(a_gnt), 32'd1);
      chk("wr_mem_we", 32'(mem_we), 32'd1);
      chk("wr_mem_addr", 32'(mem_addr), 32'd3);
      chk("wr_mem_din", 32'(mem_din), 32'h1234);
      chk("wr_brv", 32'(b_rvalid), 32'd0);
      @(negedge clk); a_we = 1'b0; #1;
      chk("rd_gnt", 32'(a_gnt), 32'd1);
      chk("rd_mem_we", 32'(mem_we), 32'd0);
      chk("wr_no_rv", 32'(a_rvalid), 32'd0);
      @(negedge clk); a_req = 1'b0; #1;
      chk("rd_arv", 32'(a_rvalid), 32'd1);
      chk("rd_ardata", 32'(a_rdata), 32'h1234);
      chk("rd_brv", 32'(b_rvalid), 32'd0);
      @(negedge clk); #1;
      chk("rd_arv_drop", 32'(a_rvalid), 32'd0);
      chk("rd_ardata_zero", 32'(a_rdata), 32'd0);
      chk("rd_brv2", 32'(b_rvalid), 32'd0);

      // 8 cycles of contention: strict alternation A,B,...
      @(negedge clk); rst = 1'b1;
      @(negedge clk); rst = 1'b0;
      a_req = 1'b1; b_req = 1'b1; a_we = 1'b1; b_we = 1'b1;
      na = 0; nb = 0;
      for (int i = 0; i < 8; i++) begin
         #1;
         chk($sformatf("alt%0d_agnt", i), 32'(a_gnt), 32'((i % 2) == 0));
         chk($sformatf("alt%0d_bgnt", i), 32'(b_gnt), 32'((i % 2) == 1));
         na += int'(a_gnt); nb += int'(b_gnt);
         @(negedge clk);
      end
      a_req = 1'b0; b_req = 1'b0; #1;
      chk("alt_na", 32'(na), 32'd4);
      chk("alt_nb", 32'(nb), 32'd4);
      chk("alt_stall", 32'(stall_cnt), 32'd8);

      // B alone three times, then contention goes to A
      @(negedge clk); b_req = 1'b1;
      for (int i = 0; i < 3; i++) begin
         #1;
         chk($sformatf("bonly%0d_bgnt", i), 32'(b_gnt), 32'd1);
         chk($sformatf("bonly%0d_agnt", i), 32'(a_gnt), 32'd0);
         @(negedge clk);
      end
      a_req = 1'b1; #1;
      chk("after_b_agnt", 32'(a_gnt), 32'd1);
      chk("after_b_bgnt", 32'(b_gnt), 32'd0);
      chk("bonly_stall", 32'(stall_cnt), 32'd8);
      @(negedge clk); a_req = 1'b0; b_req = 1'b0; #1;
      chk("after_b_stall", 32'(stall_cnt), 32'd9);

      // read granted, then reset pulse: no stale rvalid
      @(negedge clk); a_req = 1'b1; a_we = 1'b0; a_addr = 10'd7; #1;
      chk("rr_gnt", 32'(a_gnt), 32'd1);
      @(negedge clk); a_req = 1'b0; rst = 1'b1; #1;
      chk("rr_rst_arv", 32'(a_rvalid), 32'd0);
      chk("rr_rst_stall", 32'(stall_cnt), 32'd0);
      @(negedge clk); rst = 1'b0; #1;
      chk("rr_post_arv", 32'(a_rvalid), 32'd0);
      chk("rr_post_brv", 32'(b_rvalid), 32'd0);
      @(negedge clk); a_req = 1'b1; b_req = 1'b1; a_we = 1'b1; b_we = 1'b1; #1;
      chk("rr_prio_agnt", 32'(a_gnt), 32'd1);
      chk("rr_prio_bgnt", 32'(b_gnt), 32'd0);
      chk("rr_arv2", 32'(a_rvalid), 32'd0);
      chk("rr_stall", 32'(stall_cnt), 32'd0);

      // saturation: contention held until the counter pins at FFFF
      @(negedge clk); rst = 1'b1;
      @(negedge clk); rst = 1'b0;
      repeat (65534) @(negedge clk);
      #1;
      chk("sat_fffe", 32'(stall_cnt), 32'hFFFE);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk); #1;
         chk($sformatf("sat%0d", i), 32'(stall_cnt), 32'hFFFF);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
